// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester/register-file bus bundle for the two-port register-file arbiter
interface regfile_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_en;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, reg_rdata,
    input  ack_a, ack_b, rdata, dec_addr, dec_en, reg_we, reg_wdata, busy
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, reg_rdata,
    output ack_a, ack_b, rdata, dec_addr, dec_en, reg_we, reg_wdata, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter and IDLE/GRANT/ACK access sequencer for the 16 x 8 register file
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  regfile_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t state;
  logic   last_a;   // 1 = A was served last; resets to B so A wins the first tie
  logic   grant_a;
  logic   win_a;

  always_comb begin
    win_a = bus.req_a && (!bus.req_b || !last_a);
  end

  // dec_addr/reg_wdata double as the captured request; reg_we is only the
  // captured write flag while in GRANT, which is the only place it is consulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_a        <= 1'b0;
      grant_a       <= 1'b0;
      bus.ack_a     <= 1'b0;
      bus.ack_b     <= 1'b0;
      bus.dec_en    <= 1'b0;
      bus.reg_we    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.dec_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.rdata     <= '0;
    end else begin
      bus.ack_a  <= 1'b0;
      bus.ack_b  <= 1'b0;
      bus.dec_en <= 1'b0;
      bus.reg_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            state         <= GRANT;
            grant_a       <= win_a;
            last_a        <= win_a;
            bus.busy      <= 1'b1;
            bus.dec_en    <= 1'b1;
            bus.reg_we    <= win_a ? bus.we_a : bus.we_b;
            bus.dec_addr  <= win_a ? bus.addr_a : bus.addr_b;
            bus.reg_wdata <= win_a ? bus.wdata_a : bus.wdata_b;
          end
        end
        GRANT: begin
          state     <= ACK;
          bus.rdata <= bus.reg_we ? bus.reg_wdata : bus.reg_rdata;
          bus.ack_a <= grant_a;
          bus.ack_b <= !grant_a;
        end
        ACK: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter with a transaction-level reference model
module tb_regfile_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.DATA_W(8), .ADDR_W(4)) intf ();

  regfile_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf.slave)
  );

  // Register file behind the decoder: combinational read, write on the edge closing GRANT.
  logic [7:0] regs [16];
  logic [7:0] seed [16];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] <= seed[i];
    end else if (intf.dec_en && intf.reg_we) begin
      regs[intf.dec_addr] <= intf.reg_wdata;
    end
  end
  assign intf.reg_rdata = regs[intf.dec_addr];

  // Reference model: expected register contents and who was served last (0 = A, 1 = B).
  logic [7:0] mem [16];
  int         last_served;
  logic       op_we    [2];
  logic [3:0] op_addr  [2];
  logic [7:0] op_wdata [2];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    intf.we_a    = op_we[0];
    intf.addr_a  = op_addr[0];
    intf.wdata_a = op_wdata[0];
    intf.we_b    = op_we[1];
    intf.addr_b  = op_addr[1];
    intf.wdata_b = op_wdata[1];
  endtask

  task automatic rand_op(input int r);
    op_we[r]    = 1'($urandom_range(0, 1));
    op_addr[r]  = 4'($urandom_range(0, 15));
    op_wdata[r] = 8'($urandom_range(0, 255));
  endtask

  // One round: requests raised together; each requester drops its request on seeing its ack.
  task automatic do_round(input bit ra, input bit rb, input bit scramble, input bit pulse);
    int         w [2];
    int         n;
    int         idx;
    logic       ew [2];
    logic [3:0] ea [2];
    logic [7:0] ed [2];
    logic [7:0] exp_r;
    if (ra && rb) begin
      w[0] = (last_served == 1) ? 0 : 1;
      w[1] = 1 - w[0];
      n = 2;
    end else begin
      w[0] = ra ? 0 : 1;
      w[1] = 0;
      n = 1;
    end
    for (int i = 0; i < n; i++) begin
      ew[i] = op_we[w[i]];
      ea[i] = op_addr[w[i]];
      ed[i] = op_wdata[w[i]];
    end
    @(negedge clk);
    drive_ops();
    intf.req_a = ra;
    intf.req_b = rb;
    idx = 0;
    for (int cyc = 1; cyc <= 3 * n + 1 && idx < n; cyc++) begin
      @(negedge clk);
      check("ack_with_dec_en", 32'((intf.ack_a || intf.ack_b) && intf.dec_en), 32'd0);
      if (cyc == 1 && scramble) begin
        op_we[w[0]]    = ~op_we[w[0]];
        op_addr[w[0]]  = ~op_addr[w[0]];
        op_wdata[w[0]] = ~op_wdata[w[0]];
        drive_ops();
      end
      if (cyc == 1 && pulse) begin
        intf.req_a = 1'b0;
        intf.req_b = 1'b0;
      end
      if (intf.dec_en) begin
        check("grant_cycle", 32'(cyc), 32'(1 + 3 * idx));
        check("dec_addr", 32'(intf.dec_addr), 32'(ea[idx]));
        check("reg_we", 32'(intf.reg_we), 32'(ew[idx]));
        check("busy_grant", 32'(intf.busy), 32'd1);
        if (ew[idx]) check("reg_wdata", 32'(intf.reg_wdata), 32'(ed[idx]));
      end
      if (intf.ack_a || intf.ack_b) begin
        check("ack_cycle", 32'(cyc), 32'(2 + 3 * idx));
        check("ack_a", 32'(intf.ack_a), 32'(w[idx] == 0));
        check("ack_b", 32'(intf.ack_b), 32'(w[idx] == 1));
        if (ew[idx]) begin
          mem[ea[idx]] = ed[idx];
          exp_r = ed[idx];
        end else begin
          exp_r = mem[ea[idx]];
        end
        check("rdata", 32'(intf.rdata), 32'(exp_r));
        if (w[idx] == 0) intf.req_a = 1'b0;
        else intf.req_b = 1'b0;
        last_served = w[idx];
        idx++;
      end
    end
    check("acks_seen", 32'(idx), 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      seed[i] = 8'($urandom_range(0, 255));
      mem[i]  = seed[i];
    end
    last_served = 1;
    for (int r = 0; r < 2; r++) rand_op(r);
    drive_ops();
    intf.req_a = 1'b1;
    intf.req_b = 1'b0;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    // Reset held with a pending request: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ack_a", 32'(intf.ack_a), 32'd0);
      check("rst_ack_b", 32'(intf.ack_b), 32'd0);
      check("rst_dec_en", 32'(intf.dec_en), 32'd0);
      check("rst_reg_we", 32'(intf.reg_we), 32'd0);
      check("rst_busy", 32'(intf.busy), 32'd0);
      check("rst_dec_addr", 32'(intf.dec_addr), 32'd0);
      check("rst_reg_wdata", 32'(intf.reg_wdata), 32'd0);
      check("rst_rdata", 32'(intf.rdata), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_round(1'b1, 1'b0, 1'b0, 1'b0);

    // A writes 5 <= A7, then reads it back.
    op_we[0] = 1'b1; op_addr[0] = 4'h5; op_wdata[0] = 8'hA7;
    do_round(1'b1, 1'b0, 1'b0, 1'b0);
    op_we[0] = 1'b0; op_wdata[0] = 8'h00;
    do_round(1'b1, 1'b0, 1'b0, 1'b0);
    check("read_back_a7", 32'(intf.rdata), 32'hA7);

    // Both requests held from reset for 12 cycles: acks A, B, A, B at 2, 5, 8, 11.
    @(negedge clk);
    rst_n = 1'b0;
    op_we[0] = 1'b0; op_we[1] = 1'b0;
    drive_ops();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_served = 1;
    @(negedge clk);
    intf.req_a = 1'b1;
    intf.req_b = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("tie_ack_a", 32'(intf.ack_a), 32'(c == 2 || c == 8));
      check("tie_ack_b", 32'(intf.ack_b), 32'(c == 5 || c == 11));
    end
    intf.req_a = 1'b0;
    intf.req_b = 1'b0;
    last_served = 1;

    // B reads F and retargets to 0 during GRANT; the captured read still completes.
    op_we[1] = 1'b0; op_addr[1] = 4'hF; op_wdata[1] = 8'h5C;
    do_round(1'b0, 1'b1, 1'b1, 1'b0);
    check("reg15_read", 32'(intf.rdata), 32'(mem[15]));

    // One-cycle request pulse from A still completes with an ack.
    rand_op(0);
    do_round(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset during GRANT of a write to 3: write suppressed, no ack, back to IDLE.
    @(negedge clk);
    op_we[0] = 1'b1; op_addr[0] = 4'h3; op_wdata[0] = ~mem[3];
    drive_ops();
    intf.req_a = 1'b1;
    @(negedge clk);
    check("abort_dec_en_pre", 32'(intf.dec_en), 32'd1);
    check("abort_reg_we_pre", 32'(intf.reg_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_reg_we", 32'(intf.reg_we), 32'd0);
    check("abort_dec_en", 32'(intf.dec_en), 32'd0);
    check("abort_busy", 32'(intf.busy), 32'd0);
    intf.req_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_ack_a", 32'(intf.ack_a), 32'd0);
    end
    check("abort_reg3", 32'(regs[3]), 32'(mem[3]));
    rst_n = 1'b1;
    last_served = 1;
    @(negedge clk);
    check("abort_idle", 32'(intf.busy), 32'd0);

    // Randomized rounds against the model.
    for (int k = 0; k < 40; k++) begin
      int s;
      s = $urandom_range(1, 3);
      rand_op(0);
      rand_op(1);
      do_round(1'(s & 1), 1'((s >> 1) & 1), 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final_regs", 32'(regs[i]), 32'(mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
